// File: rtl/handshake_pipe_fifo_patting_pkg.sv
// Shared definitions for the handshake pipe FIFO.
//   HS_DATA_W : default payload width of the valid/ready link, shared with the patting slices
//   is_pow2() : elaboration-time helper used to validate the DEPTH parameter
package handshake_pipe_fifo_patting_pkg;

    localparam int HS_DATA_W = 32;

    // True for powers of two that are at least 2.
    function automatic bit is_pow2(input int v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/handshake_pipe_fifo_patting.sv
// Synchronous FIFO stage on a valid/ready link with registered ready, valid and flags.
// It gives full timing isolation between the upstream and downstream sides.
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   clr               synchronous flush; takes priority over push/pop
//   s_valid/s_data    upstream word and its valid
//   s_ready           registered: the FIFO can accept a word
//   m_valid/m_data    registered head-valid; head word read from the flop array
//   m_ready           downstream accepts the head word
//   level             occupancy, 0..DEPTH
//   almost_full       registered: level >= AF_LEVEL
module handshake_pipe_fifo_patting
    import handshake_pipe_fifo_patting_pkg::*;
#(
    parameter int DATA_W   = HS_DATA_W,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       s_valid,
    input  logic [DATA_W-1:0]          s_data,
    output logic                       s_ready,
    output logic                       m_valid,
    output logic [DATA_W-1:0]          m_data,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       almost_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    generate
        if (!is_pow2(DEPTH)) begin : g_bad_depth
            $error("handshake_pipe_fifo_patting: DEPTH must be a power of two >= 2");
        end
        if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
            $error("handshake_pipe_fifo_patting: AF_LEVEL must lie in 1..DEPTH");
        end
    endgenerate

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q,  level_d;
    logic              s_ready_q;
    logic              m_valid_q;
    logic              almost_full_q;

    logic push;
    logic pop;

    // Handshakes only ever see the registered flags, so no input feeds an output combinationally.
    assign push = s_valid & s_ready_q;
    assign pop  = m_valid_q & m_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clr) begin
            // A flush discards any handshake that happens in the same cycle.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            // Pointers are exactly PTR_W bits, so they wrap DEPTH-1 -> 0 on their own.
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
        end
    end

    // All flags come from the same level_d, so they can never disagree with each other.
    // With level_d forced to 0 on a flush, the flags settle to
    // s_ready=1, m_valid=0 and almost_full=0 (AF_LEVEL is at least 1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            s_ready_q     <= 1'b0;
            m_valid_q     <= 1'b0;
            almost_full_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            s_ready_q     <= (level_d != LVL_W'(DEPTH));
            m_valid_q     <= (level_d != '0);
            almost_full_q <= (level_d >= LVL_W'(AF_LEVEL));
        end
    end

    // The storage array is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    assign m_data      = mem_q[rd_ptr_q];
    assign s_ready     = s_ready_q;
    assign m_valid     = m_valid_q;
    assign level       = level_q;
    assign almost_full = almost_full_q;

endmodule

// File: tb/tb_handshake_pipe_fifo_patting.sv
module tb_handshake_pipe_fifo_patting;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int AF_LVL = 6;

    logic              clk;
    logic              rst_n;
    logic              clr;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ready;
    logic [3:0]        level;
    logic              almost_full;

    int total;
    int bad;

    handshake_pipe_fifo_patting #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LVL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_ready     (m_ready),
        .level       (level),
        .almost_full (almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus helper: push n words base..base+n-1 with m_ready low. Starts and ends on a negedge.
    task automatic push_words(input logic [DATA_W-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = base + DATA_W'(i);
            m_ready = 1'b0;
            @(negedge clk);
        end
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (s_ready !== 1'b0 || m_valid !== 1'b0 || level !== 4'd0 || almost_full !== 1'b0) begin
            bad++;
            $display("FAIL reset_hold: s_ready=%b m_valid=%b level=%0d af=%b, required 0 0 0 0",
                     s_ready, m_valid, level, almost_full);
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (s_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: s_ready=%b required 0 before first edge", s_ready);
        end
        @(negedge clk);
        total++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || level !== 4'd0) begin
            bad++;
            $display("FAIL reset_first_edge: s_ready=%b m_valid=%b level=%0d, required 1 0 0",
                     s_ready, m_valid, level);
        end
        $display("test_reset: done");
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            s_valid = 1'b1;
            s_data  = DATA_W'(i);
            m_ready = 1'b0;
            @(negedge clk);
            total++;
            if (level !== 4'(i + 1) || almost_full !== (i + 1 >= AF_LVL) ||
                s_ready !== (i + 1 != DEPTH) || m_valid !== 1'b1 || m_data !== 32'h0) begin
                bad++;
                $display("FAIL fill_%0d: level=%0d af=%b s_ready=%b m_valid=%b m_data=%h, required %0d %b %b 1 00000000",
                         i, level, almost_full, s_ready, m_valid, m_data,
                         i + 1, (i + 1 >= AF_LVL), (i + 1 != DEPTH));
            end
        end
        s_valid = 1'b0;
        $display("test_fill: level=%0d", level);
    endtask

    task automatic test_drain();
        m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            total++;
            if (m_valid !== 1'b1 || m_data !== DATA_W'(i)) begin
                bad++;
                $display("FAIL drain_%0d: m_valid=%b m_data=%h, required 1 %h", i, m_valid, m_data, DATA_W'(i));
            end
            @(negedge clk);
            total++;
            if (level !== 4'(DEPTH - 1 - i) || s_ready !== 1'b1) begin
                bad++;
                $display("FAIL drain_level_%0d: level=%0d s_ready=%b, required %0d 1",
                         i, level, s_ready, DEPTH - 1 - i);
            end
        end
        total++;
        if (m_valid !== 1'b0 || level !== 4'd0 || almost_full !== 1'b0) begin
            bad++;
            $display("FAIL drain_empty: m_valid=%b level=%0d af=%b, required 0 0 0", m_valid, level, almost_full);
        end
        m_ready = 1'b0;
        $display("test_drain: done");
    endtask

    task automatic test_stream();
        int pops;
        pops = 0;
        m_ready = 1'b1;
        for (int k = 0; k <= 100; k++) begin
            if (k >= 1) begin
                total++;
                if (level !== 4'd1 || m_valid !== 1'b1 || s_ready !== 1'b1 ||
                    m_data !== (32'hC000_0000 | DATA_W'(k - 1))) begin
                    bad++;
                    $display("FAIL stream_%0d: level=%0d m_valid=%b s_ready=%b m_data=%h, required 1 1 1 %h",
                             k, level, m_valid, s_ready, m_data, 32'hC000_0000 | DATA_W'(k - 1));
                end
                pops++;
            end
            s_valid = (k < 100);
            s_data  = 32'hC000_0000 | DATA_W'(k);
            @(negedge clk);
        end
        s_valid = 1'b0;
        total++;
        if (level !== 4'd0 || m_valid !== 1'b0 || pops != 100) begin
            bad++;
            $display("FAIL stream_end: level=%0d m_valid=%b pops=%0d, required 0 0 100", level, m_valid, pops);
        end
        m_ready = 1'b0;
        $display("test_stream: %0d words", pops);
    endtask

    task automatic test_full_pop();
        push_words(32'h10, DEPTH);
        total++;
        if (level !== 4'd8 || s_ready !== 1'b0 || m_data !== 32'h10) begin
            bad++;
            $display("FAIL full_state: level=%0d s_ready=%b m_data=%h, required 8 0 00000010", level, s_ready, m_data);
        end
        s_valid = 1'b1; s_data = 32'h55; m_ready = 1'b1;
        @(negedge clk);
        total++;
        if (level !== 4'd7 || s_ready !== 1'b1 || m_data !== 32'h11) begin
            bad++;
            $display("FAIL full_pop: level=%0d s_ready=%b m_data=%h, required 7 1 00000011", level, s_ready, m_data);
        end
        m_ready = 1'b0;
        @(negedge clk);
        s_valid = 1'b0;
        total++;
        if (level !== 4'd8 || s_ready !== 1'b0) begin
            bad++;
            $display("FAIL full_repush: level=%0d s_ready=%b, required 8 0", level, s_ready);
        end
        m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            total++;
            if (m_data !== ((i == DEPTH - 1) ? 32'h55 : 32'h11 + DATA_W'(i))) begin
                bad++;
                $display("FAIL full_drain_%0d: m_data=%h, required %h", i, m_data,
                         (i == DEPTH - 1) ? 32'h55 : 32'h11 + DATA_W'(i));
            end
            @(negedge clk);
        end
        m_ready = 1'b0;
        total++;
        if (level !== 4'd0 || m_valid !== 1'b0) begin
            bad++;
            $display("FAIL full_drain_end: level=%0d m_valid=%b, required 0 0", level, m_valid);
        end
        $display("test_full_pop: done");
    endtask

    task automatic test_clr();
        push_words(32'h20, 5);
        total++;
        if (level !== 4'd5 || almost_full !== 1'b0) begin
            bad++;
            $display("FAIL clr_pre: level=%0d af=%b, required 5 0", level, almost_full);
        end
        clr = 1'b1; s_valid = 1'b1; s_data = 32'h77; m_ready = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        total++;
        if (level !== 4'd0 || m_valid !== 1'b0 || s_ready !== 1'b1 || almost_full !== 1'b0) begin
            bad++;
            $display("FAIL clr_flush: level=%0d m_valid=%b s_ready=%b af=%b, required 0 0 1 0",
                     level, m_valid, s_ready, almost_full);
        end
        s_valid = 1'b1; s_data = 32'hA5; m_ready = 1'b0;
        @(negedge clk);
        s_valid = 1'b0;
        total++;
        if (level !== 4'd1 || m_valid !== 1'b1 || m_data !== 32'hA5) begin
            bad++;
            $display("FAIL clr_first_word: level=%0d m_valid=%b m_data=%h, required 1 1 000000a5", level, m_valid, m_data);
        end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        total++;
        if (level !== 4'd0 || m_valid !== 1'b0) begin
            bad++;
            $display("FAIL clr_drain: level=%0d m_valid=%b, required 0 0", level, m_valid);
        end
        $display("test_clr: done");
    endtask

    task automatic test_async_reset();
        push_words(32'h40, 7);
        total++;
        if (almost_full !== 1'b1 || level !== 4'd7) begin
            bad++;
            $display("FAIL areset_pre: level=%0d af=%b, required 7 1", level, almost_full);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (s_ready !== 1'b0 || m_valid !== 1'b0 || level !== 4'd0 || almost_full !== 1'b0) begin
            bad++;
            $display("FAIL areset_mid: s_ready=%b m_valid=%b level=%0d af=%b, required 0 0 0 0",
                     s_ready, m_valid, level, almost_full);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || level !== 4'd0) begin
            bad++;
            $display("FAIL areset_recover: s_ready=%b m_valid=%b level=%0d, required 1 0 0", s_ready, m_valid, level);
        end
        $display("test_async_reset: done");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_fill();
        test_drain();
        test_stream();
        test_full_pop();
        test_clr();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
